mem_access_ctrl: RTL and testbench

//  M-stage load/store unit; next generation of the combinational byte-select path. Issues one access at a time
//  on an SRAM-like split address/data bus with variable latency. Stalls the pipeline until the access completes.

---
 rtl/mem_access_ctrl_pkg.sv | 36 +++
 rtl/mem_lane_fmt.sv | 110 +++++++++++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcodes, bus size codes and FSM state type for the M-stage load/store unit.
// Opcode values match the mycpu EXE_*_OP encoding.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_LWL_OP = 8'b0010_0010;
    localparam logic [7:0] EXE_LW_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b0010_0101;
    localparam logic [7:0] EXE_LWR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_SB_OP  = 8'b0010_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b0010_1001;
    localparam logic [7:0] EXE_SWL_OP = 8'b0010_1010;
    localparam logic [7:0] EXE_SW_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_SWR_OP = 8'b0010_1110;

    localparam logic [1:0] MEMSZ_BYTE = 2'd0;
    localparam logic [1:0] MEMSZ_HALF = 2'd1;
    localparam logic [1:0] MEMSZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Unaligned-word ops always go out on a word-aligned bus address.
    function automatic logic is_lr_op(input logic [7:0] op);
        return (op == EXE_LWL_OP) || (op == EXE_LWR_OP) ||
               (op == EXE_SWL_OP) || (op == EXE_SWR_OP);
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: store strobes/data and size from the live M-stage op,
// load result from the latched op and bus read data, plus address-error detection.
module mem_lane_fmt #(
    parameter int DATA_W = 32,
    parameter int LANES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [7:0]        m_op,
    input  logic [OFF_W-1:0]  m_off,
    input  logic [31:0]       m_rt,
    input  logic              m_memwrite,
    input  logic              m_memtoreg,
    input  logic [7:0]        q_op,
    input  logic [OFF_W-1:0]  q_off,
    input  logic [31:0]       q_rt,
    input  logic [DATA_W-1:0] rdata,
    output logic [LANES-1:0]  strb,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        size,
    output logic [31:0]       ld_result,
    output logic              adel,
    output logic              ades
);
    import mem_access_ctrl_pkg::*;

    localparam int WORDS = DATA_W / 32;

    logic [31:0]      mw;
    logic [OFF_W-1:0] st_base;

    // st_base is the byte-lane index of the addressed word (4*w).
    generate
        if (WORDS > 1) begin : g_wide
            assign mw      = rdata[{q_off[OFF_W-1:2], 5'd0} +: 32];
            assign st_base = {m_off[OFF_W-1:2], 2'b00};
        end else begin : g_narrow
            assign mw      = rdata;
            assign st_base = '0;
        end
    endgenerate

    logic [1:0]  sb;
    logic [3:0]  nib;
    logic [31:0] word;

    always_comb begin
        sb   = m_off[1:0];
        nib  = 4'h0;
        word = m_rt;
        strb = '0;
        size = MEMSZ_WORD;
        case (m_op)
            EXE_LB_OP, EXE_LBU_OP: size = MEMSZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP: size = MEMSZ_HALF;
            EXE_SB_OP: begin
                size = MEMSZ_BYTE;
                word = {4{m_rt[7:0]}};
                strb = LANES'(1) << m_off;
            end
            EXE_SH_OP: begin
                size = MEMSZ_HALF;
                word = {2{m_rt[15:0]}};
                strb = LANES'(3) << m_off;
            end
            EXE_SW_OP:  nib = 4'hF;
            EXE_SWL_OP: begin
                nib  = 4'hF >> (2'd3 - sb);
                word = m_rt >> {2'd3 - sb, 3'b000};
            end
            EXE_SWR_OP: begin
                nib  = 4'hF << sb;
                word = m_rt << {sb, 3'b000};
            end
            default: ;
        endcase
        strb  = strb | (LANES'(nib) << st_base);
        wdata = {WORDS{word}};
    end

    logic [1:0]  lb;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  shl;
    logic [4:0]  shr;

    always_comb begin
        lb     = q_off[1:0];
        byte_v = mw[{lb, 3'b000} +: 8];
        half_v = mw[{lb[1], 4'b0000} +: 16];
        shl    = {2'd3 - lb, 3'b000};
        shr    = {lb, 3'b000};
        case (q_op)
            EXE_LB_OP:  ld_result = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: ld_result = {24'h0, byte_v};
            EXE_LH_OP:  ld_result = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: ld_result = {16'h0, half_v};
            EXE_LWL_OP: ld_result = (mw << shl) | (q_rt & ~(32'hFFFF_FFFF << shl));
            EXE_LWR_OP: ld_result = (mw >> shr) | (q_rt & ~(32'hFFFF_FFFF >> shr));
            default:    ld_result = mw;
        endcase
    end

    assign adel = m_memtoreg &
                  ((((m_op == EXE_LH_OP) || (m_op == EXE_LHU_OP)) && m_off[0]) ||
                   ((m_op == EXE_LW_OP) && (m_off[1:0] != 2'b00)));
    assign ades = m_memwrite &
                  (((m_op == EXE_SH_OP) && m_off[0]) ||
                   ((m_op == EXE_SW_OP) && (m_off[1:0] != 2'b00)));

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store controller: one outstanding access on a split addr/data bus,
// stalls the pipeline until completion and drains orphaned responses after a flush.
module mem_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          alucontrolM,
    input  logic [31:0]         aluoutM,
    input  logic [31:0]         writedataM,
    input  logic                memwriteM,
    input  logic                memtoregM,
    input  logic                flushM,
    output logic                stallM,
    output logic [31:0]         readdataM,
    output logic                resp_validM,
    output logic                adelM,
    output logic                adesM,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);
    import mem_access_ctrl_pkg::*;

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    state_e              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [31:0]         rt_q, rt_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [LANES-1:0]    strb_q, strb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [LANES-1:0]    f_strb;
    logic [DATA_W-1:0]   f_wdata;
    logic [1:0]          f_size;
    logic [31:0]         f_ld;
    logic                mem_op;
    logic                start;

    mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
        .m_op       (alucontrolM),
        .m_off      (aluoutM[OFF_W-1:0]),
        .m_rt       (writedataM),
        .m_memwrite (memwriteM),
        .m_memtoreg (memtoregM),
        .q_op       (op_q),
        .q_off      (off_q),
        .q_rt       (rt_q),
        .rdata      (data_rdata),
        .strb       (f_strb),
        .wdata      (f_wdata),
        .size       (f_size),
        .ld_result  (f_ld),
        .adel       (adelM),
        .ades       (adesM)
    );

    always_comb begin
        mem_op      = memwriteM | memtoregM;
        start       = resetn & mem_op & ~adelM & ~adesM & ~flushM;
        state_d     = state_q;
        op_d        = op_q;
        rt_d        = rt_q;
        off_d       = off_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        size_d      = size_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stallM      = 1'b0;
        resp_validM = 1'b0;
        data_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stallM  = 1'b1;
                    state_d = ST_REQ;
                    op_d    = alucontrolM;
                    rt_d    = writedataM;
                    off_d   = aluoutM[OFF_W-1:0];
                    addr_d  = {aluoutM[ADDR_W-1:2], is_lr_op(alucontrolM) ? 2'b00 : aluoutM[1:0]};
                    wr_d    = memwriteM;
                    size_d  = f_size;
                    strb_d  = memwriteM ? f_strb : '0;
                    wdata_d = memwriteM ? f_wdata : '0;
                end
            end
            ST_REQ: begin
                stallM   = 1'b1;
                data_req = 1'b1;
                if (data_addr_ok)
                    state_d = flushM ? ST_DRAIN : ST_WAIT;
                else if (flushM)
                    state_d = ST_IDLE;
            end
            ST_WAIT: begin
                stallM = 1'b1;
                if (data_data_ok) begin
                    // A flushed access still consumed its response, so nothing is left to drain.
                    state_d = flushM ? ST_IDLE : ST_DONE;
                    if (!flushM && !wr_q)
                        rdata_d = f_ld;
                end else if (flushM) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                resp_validM = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_DRAIN: begin
                stallM = mem_op;
                if (data_data_ok)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rt_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rt_q    <= rt_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_wr    = wr_q & (state_q == ST_REQ);
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = strb_q;
    assign data_wdata = wdata_q;
    assign readdataM  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: a 32-bit and a 64-bit instance share the M-stage inputs and bus handshakes;
// a vector table covers formatting, hand sequences cover faults, flush/drain and async reset.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [7:0]  alucontrolM;
    logic [31:0] aluoutM, writedataM;
    logic        memwriteM, memtoregM, flushM;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] rdata32;
    logic [63:0] rdata64;

    logic        stall32, resp32, adel32, ades32, req32, wr32;
    logic [31:0] rd32, addr32, wdata32;
    logic [1:0]  size32;
    logic [3:0]  strb32;
    logic        stall64, resp64, adel64, ades64, req64, wr64;
    logic [31:0] rd64, addr64;
    logic [63:0] wdata64;
    logic [1:0]  size64;
    logic [7:0]  strb64;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .resetn(resetn), .alucontrolM(alucontrolM), .aluoutM(aluoutM),
        .writedataM(writedataM), .memwriteM(memwriteM), .memtoregM(memtoregM), .flushM(flushM),
        .stallM(stall32), .readdataM(rd32), .resp_validM(resp32), .adelM(adel32), .adesM(ades32),
        .data_req(req32), .data_wr(wr32), .data_size(size32), .data_addr(addr32),
        .data_wstrb(strb32), .data_wdata(wdata32), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(rdata32)
    );

    mem_access_ctrl #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .resetn(resetn), .alucontrolM(alucontrolM), .aluoutM(aluoutM),
        .writedataM(writedataM), .memwriteM(memwriteM), .memtoregM(memtoregM), .flushM(flushM),
        .stallM(stall64), .readdataM(rd64), .resp_validM(resp64), .adelM(adel64), .adesM(ades64),
        .data_req(req64), .data_wr(wr64), .data_size(size64), .data_addr(addr64),
        .data_wstrb(strb64), .data_wdata(wdata64), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(rdata64)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] mem;
        logic        st;
        logic [1:0]  size;
        logic [31:0] baddr;
        logic [3:0]  s32;
        logic [7:0]  s64;
        logic [31:0] wword;
        logic [31:0] res;
        int          a_dly;
        int          d_dly;
    } vec_t;

    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    vec_t vt[14];
    int   checks = 0;
    int   errors = 0;
    int   cur    = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", nm, cur, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int stalls;
        stalls       = 0;
        alucontrolM  = v.op;
        aluoutM      = v.addr;
        writedataM   = v.rt;
        memwriteM    = v.st;
        memtoregM    = ~v.st;
        rdata32      = v.mem;
        rdata64      = v.addr[2] ? {v.mem, JUNK} : {JUNK, v.mem};
        #1;
        chk("idle_stall32", stall32, 1);
        chk("idle_stall64", stall64, 1);
        if (stall32) stalls++;
        @(posedge clk); #1;
        chk("req32", req32, 1);
        chk("req64", req64, 1);
        chk("addr32", addr32, v.baddr);
        chk("addr64", addr64, v.baddr);
        chk("size32", size32, v.size);
        chk("size64", size64, v.size);
        chk("wr32", wr32, v.st);
        chk("wr64", wr64, v.st);
        chk("strb32", strb32, v.s32);
        chk("strb64", strb64, v.s64);
        if (v.st) begin
            chk("wdata32", wdata32, v.wword);
            chk("wdata64", wdata64, {v.wword, v.wword});
        end
        for (int k = 0; k < v.a_dly; k++) begin
            if (stall32) stalls++;
            @(posedge clk); #1;
        end
        chk("req_held", req32 & req64, 1);
        data_addr_ok = 1'b1;
        if (stall32) stalls++;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        chk("wait_noreq", req32 | req64, 0);
        for (int k = 0; k < v.d_dly; k++) begin
            if (stall32) stalls++;
            @(posedge clk); #1;
        end
        data_data_ok = 1'b1;
        if (stall32) stalls++;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        chk("done_resp32", resp32, 1);
        chk("done_resp64", resp64, 1);
        chk("done_stall", stall32 | stall64, 0);
        if (!v.st) begin
            chk("rdata32", rd32, v.res);
            chk("rdata64", rd64, v.res);
        end
        chk("stall_cycles", stalls, 3 + v.a_dly + v.d_dly);
        memwriteM = 1'b0;
        memtoregM = 1'b0;
        @(posedge clk); #1;
        chk("resp_1cyc", resp32 | resp64, 0);
    endtask

    initial begin
        vt[0]  = '{EXE_LW_OP,  32'h1004, 32'h0,        32'hDEADBEEF, 1'b0, 2'd2, 32'h1004, 4'h0, 8'h00, 32'h0,        32'hDEADBEEF, 0, 0};
        vt[1]  = '{EXE_SB_OP,  32'h1003, 32'h12345678, 32'h0,        1'b1, 2'd0, 32'h1003, 4'h8, 8'h08, 32'h78787878, 32'h0,        1, 2};
        vt[2]  = '{EXE_LWL_OP, 32'h2001, 32'h11223344, 32'hAABBCCDD, 1'b0, 2'd2, 32'h2000, 4'h0, 8'h00, 32'h0,        32'hCCDD3344, 2, 1};
        vt[3]  = '{EXE_LWR_OP, 32'h2001, 32'h11223344, 32'hAABBCCDD, 1'b0, 2'd2, 32'h2000, 4'h0, 8'h00, 32'h0,        32'h11AABBCC, 0, 3};
        vt[4]  = '{EXE_LB_OP,  32'h4006, 32'h0,        32'h80FF7F01, 1'b0, 2'd0, 32'h4006, 4'h0, 8'h00, 32'h0,        32'hFFFFFFFF, 3, 0};
        vt[5]  = '{EXE_LBU_OP, 32'h4006, 32'h0,        32'h80FF7F01, 1'b0, 2'd0, 32'h4006, 4'h0, 8'h00, 32'h0,        32'h000000FF, 1, 1};
        vt[6]  = '{EXE_LH_OP,  32'h4006, 32'h0,        32'h80FF7F01, 1'b0, 2'd1, 32'h4006, 4'h0, 8'h00, 32'h0,        32'hFFFF80FF, 0, 1};
        vt[7]  = '{EXE_LHU_OP, 32'h4006, 32'h0,        32'h80FF7F01, 1'b0, 2'd1, 32'h4006, 4'h0, 8'h00, 32'h0,        32'h000080FF, 5, 5};
        vt[8]  = '{EXE_SH_OP,  32'h5006, 32'hCAFEBABE, 32'h0,        1'b1, 2'd1, 32'h5006, 4'hC, 8'hC0, 32'hBABEBABE, 32'h0,        2, 2};
        vt[9]  = '{EXE_SW_OP,  32'h500C, 32'h01020304, 32'h0,        1'b1, 2'd2, 32'h500C, 4'hF, 8'hF0, 32'h01020304, 32'h0,        0, 0};
        vt[10] = '{EXE_SWL_OP, 32'h6001, 32'h11223344, 32'h0,        1'b1, 2'd2, 32'h6000, 4'h3, 8'h03, 32'h00001122, 32'h0,        1, 0};
        vt[11] = '{EXE_SWR_OP, 32'h6005, 32'h11223344, 32'h0,        1'b1, 2'd2, 32'h6004, 4'hE, 8'hE0, 32'h22334400, 32'h0,        0, 4};
        vt[12] = '{EXE_LWL_OP, 32'h2003, 32'h11223344, 32'hAABBCCDD, 1'b0, 2'd2, 32'h2000, 4'h0, 8'h00, 32'h0,        32'hAABBCCDD, 1, 1};
        vt[13] = '{EXE_LWR_OP, 32'h2000, 32'h11223344, 32'hAABBCCDD, 1'b0, 2'd2, 32'h2000, 4'h0, 8'h00, 32'h0,        32'hAABBCCDD, 0, 2};

        resetn = 1'b0; alucontrolM = 8'h0; aluoutM = 32'h0; writedataM = 32'h0;
        memwriteM = 1'b0; memtoregM = 1'b0; flushM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; rdata32 = 32'h0; rdata64 = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall32 | stall64, 0);
        chk("rst_resp", resp32 | resp64, 0);
        chk("rst_req", req32 | req64, 0);
        chk("rst_wr", wr32 | wr64, 0);
        chk("rst_rdata", {rd64, rd32}, 0);
        chk("rst_addr", {addr64, addr32}, 0);
        chk("rst_strb", {strb64, strb32}, 0);
        chk("rst_wdata32", wdata32, 0);
        chk("rst_wdata64", wdata64, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            cur = i;
            run_vec(vt[i]);
        end

        // Address errors: no request, no stall.
        cur = 100;
        alucontrolM = EXE_LH_OP; aluoutM = 32'h3001; memtoregM = 1'b1; #1;
        chk("adel32", adel32, 1);
        chk("adel64", adel64, 1);
        chk("adel_no_ades", ades32 | ades64, 0);
        chk("adel_nostall", stall32 | stall64, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("adel_noreq", req32 | req64, 0);
        end
        alucontrolM = EXE_SW_OP; aluoutM = 32'h3002; memtoregM = 1'b0; memwriteM = 1'b1; #1;
        chk("ades32", ades32, 1);
        chk("ades64", ades64, 1);
        chk("ades_nostall", stall32 | stall64, 0);
        @(posedge clk); #1;
        chk("ades_noreq", req32 | req64, 0);
        alucontrolM = EXE_LW_OP; memwriteM = 1'b0; #1;
        chk("adel_gated", adel32 | adel64 | ades32 | ades64, 0);
        @(posedge clk); #1;

        // Flush in REQ before addr_ok drops the request.
        cur = 101;
        alucontrolM = EXE_LW_OP; aluoutM = 32'h7100; memtoregM = 1'b1;
        @(posedge clk); #1;
        chk("fr_req", req32 & req64, 1);
        flushM = 1'b1;
        @(posedge clk); #1;
        flushM = 1'b0; memtoregM = 1'b0; #1;
        chk("fr_dropped", req32 | req64 | stall32 | stall64, 0);
        @(posedge clk); #1;

        // Flush in WAIT -> DRAIN; the late response is discarded.
        cur = 102;
        alucontrolM = EXE_LW_OP; aluoutM = 32'h7000; memtoregM = 1'b1;
        rdata32 = 32'h0BAD0BAD; rdata64 = {2{32'h0BAD0BAD}};
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        flushM = 1'b1;
        @(posedge clk); #1;
        flushM = 1'b0; aluoutM = 32'h7008; #1;
        chk("drain_stall32", stall32, 1);
        chk("drain_stall64", stall64, 1);
        repeat (2) begin
            chk("drain_noreq", req32 | req64, 0);
            chk("drain_noresp", resp32 | resp64, 0);
            @(posedge clk); #1;
        end
        data_data_ok = 1'b1;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        chk("drain_noresp_end", resp32 | resp64, 0);
        chk("drain_rd_kept32", rd32, vt[13].res);
        chk("drain_rd_kept64", rd64, vt[13].res);
        run_vec('{EXE_LW_OP, 32'h7008, 32'h0, 32'h600DF00D, 1'b0, 2'd2, 32'h7008, 4'h0, 8'h00, 32'h0, 32'h600DF00D, 1, 1});

        // Async reset while the request is on the bus.
        cur = 103;
        alucontrolM = EXE_LW_OP; aluoutM = 32'h8004; memtoregM = 1'b1;
        @(posedge clk); #1;
        chk("rr_req", req32 & req64, 1);
        resetn = 1'b0;
        #1;
        chk("rr_req_low", req32 | req64, 0);
        chk("rr_stall_low", stall32 | stall64, 0);
        chk("rr_rd_clr", {rd64, rd32}, 0);
        memtoregM = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_vec('{EXE_LW_OP, 32'h8004, 32'h0, 32'h13579BDF, 1'b0, 2'd2, 32'h8004, 4'h0, 8'h00, 32'h0, 32'h13579BDF, 2, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
